// File: rtl/ir_fetch.sv
// Instruction-register fetch unit: issues a memory request on irwrite, waits for mem_ready,
// and loads NOP_WORD (flagging fetch_err) if memory stays silent for TIMEOUT wait cycles.

package mips_decls_p;
    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;

    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_BEQ   = 6'h04;
    localparam opcode_t OP_LW    = 6'h23;
    localparam opcode_t OP_SW    = 6'h2B;
endpackage

module ir_fetch #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   irwrite,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   stall,
    output logic [31:0]            instr,
    output mips_decls_p::opcode_t  opcode,
    output mips_decls_p::funct_t   funct,
    output logic [4:0]             rs,
    output logic [4:0]             rt,
    output logic [4:0]             rd,
    output logic [15:0]            imm,
    output logic                   instr_valid,
    output logic                   fetch_err
);

    // state | meaning
    // IDLE  | no fetch outstanding; irwrite starts one (or completes it at once if mem_ready)
    // WAIT  | request outstanding; counting cycles until mem_ready or timeout
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [31:0] ir;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ir          <= 32'h0;
            wait_cnt    <= 8'd0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (irwrite) begin
                        if (mem_ready) begin
                            ir          <= mem_rdata;
                            instr_valid <= 1'b1;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 8'd0;
                        end
                    end
                end
                WAIT: begin
                    // A late mem_ready on the final wait cycle still delivers real data.
                    if (mem_ready) begin
                        ir          <= mem_rdata;
                        instr_valid <= 1'b1;
                        fetch_err   <= 1'b0;
                        state       <= IDLE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        ir          <= NOP_WORD;
                        instr_valid <= 1'b1;
                        fetch_err   <= 1'b1;
                        state       <= IDLE;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by reset so a held irwrite cannot raise a request during reset.
    assign mem_req = reset && ((state == IDLE && irwrite) || state == WAIT);
    assign stall   = mem_req && !mem_ready;

    assign instr  = ir;
    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign imm    = ir[15:0];
    assign funct  = ir[5:0];

endmodule

// File: tb/tb_ir_fetch.sv
// Self-checking bench for ir_fetch: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the fetch protocol.

module tb_ir_fetch;

    localparam int unsigned TIMEOUT  = 16;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        irwrite;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_req;
    logic        stall;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        instr_valid;
    logic        fetch_err;

    ir_fetch #(.TIMEOUT(TIMEOUT), .NOP_WORD(NOP_WORD)) dut (
        .clk(clk), .reset(reset), .irwrite(irwrite), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_req(mem_req), .stall(stall), .instr(instr),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
        .instr_valid(instr_valid), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a fetch is either outstanding or not; an outstanding fetch
    // has aged some number of silent cycles and is abandoned once that reaches TIMEOUT.
    bit          m_pending;
    int          m_silent;
    logic [31:0] m_ir;
    bit          m_valid;
    bit          m_err;
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 0;
        m_silent  = 0;
        m_ir      = 32'h0;
        m_valid   = 0;
        m_err     = 0;
    endtask

    task automatic model_edge(input bit irw, input bit rdy, input logic [31:0] data);
        if (!m_pending) begin
            if (irw && rdy) begin
                m_ir    = data;
                m_valid = 1;
            end else if (irw) begin
                m_pending = 1;
                m_silent  = 0;
            end
        end else if (rdy) begin
            m_ir      = data;
            m_valid   = 1;
            m_err     = 0;
            m_pending = 0;
        end else begin
            m_silent++;
            if (m_silent == TIMEOUT) begin
                m_ir      = NOP_WORD;
                m_valid   = 1;
                m_err     = 1;
                m_pending = 0;
            end
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".instr"},  instr,       m_ir);
        chk({tag, ".valid"},  instr_valid, m_valid);
        chk({tag, ".err"},    fetch_err,   m_err);
        chk({tag, ".fields"}, {opcode, rs, rt, rd, funct, imm},
            {m_ir[31:26], m_ir[25:21], m_ir[20:16], m_ir[15:11], m_ir[5:0], m_ir[15:0]} & 32'hFFFF_FFFF);
    endtask

    // One clock: drive at the falling edge, check combinational outputs, clock, check state.
    task automatic step(input bit irw, input bit rdy, input logic [31:0] data, input string tag);
        logic exp_req;
        @(negedge clk);
        irwrite   = irw;
        mem_ready = rdy;
        mem_rdata = data;
        #1;
        exp_req = m_pending || irw;
        chk({tag, ".mem_req"}, mem_req, exp_req);
        chk({tag, ".stall"},   stall,   exp_req && !rdy);
        last_stall = stall;
        @(posedge clk);
        model_edge(irw, rdy, data);
        #1;
        check_regs(tag);
    endtask

    task automatic pulse_reset(input bit irw, input string tag);
        @(negedge clk);
        irwrite   = irw;
        mem_ready = 1'b1;
        reset     = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            mem_rdata = (i % 2 == 0) ? 32'hDEAD_BEEF : ~32'hDEAD_BEEF;
            #1;
            chk({tag, ".rst_req"},   mem_req, 1'b0);
            chk({tag, ".rst_stall"}, stall,   1'b0);
            check_regs({tag, ".rst"});
            @(negedge clk);
        end
        reset     = 1'b1;
        irwrite   = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        int guard;
        reset     = 1'b1;
        irwrite   = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        model_reset();

        // Reset while read data toggles and irwrite is held high.
        #2 reset = 1'b0;
        pulse_reset(1'b1, "reset_toggle");

        // Zero-latency memory.
        step(1, 1, 32'h0123_4820, "zero_lat");
        chk("zero_lat.stall_seen", last_stall, 1'b0);
        chk("zero_lat.opcode", opcode, 6'h00);
        chk("zero_lat.funct",  funct,  6'h20);
        chk("zero_lat.rd",     rd,     5'd9);

        // mem_ready ignored while idle with no request.
        step(0, 1, 32'hFFFF_FFFF, "idle_ready");

        // Three-cycle memory latency.
        cnt = 0;
        step(1, 0, 32'h0, "lat3.req");    cnt += int'(last_stall);
        step(1, 0, 32'h0, "lat3.w1");     cnt += int'(last_stall);
        step(0, 0, 32'h0, "lat3.w2");     cnt += int'(last_stall);
        step(0, 1, 32'h8C49_0004, "lat3.done"); cnt += int'(last_stall);
        chk("lat3.stall_cycles", cnt, 3);
        chk("lat3.opcode", opcode, 6'h23);
        chk("lat3.imm",    imm,    16'h0004);
        chk("lat3.err",    fetch_err, 1'b0);

        // Memory never answers: TIMEOUT stalled waiting cycles after the request cycle.
        step(1, 0, 32'h0, "to.req");
        chk("to.req_stall", last_stall, 1'b1);
        cnt = 0;
        guard = 0;
        while (m_pending && guard < TIMEOUT + 4) begin
            step(0, 0, 32'hA5A5_A5A5, "to.wait");
            cnt += int'(last_stall);
            guard++;
        end
        chk("to.no_hang", m_pending, 1'b0);
        chk("to.stall_cycles", cnt, TIMEOUT);
        chk("to.instr",   instr,     32'h0);
        chk("to.err",     fetch_err, 1'b1);
        #1 chk("to.mem_req", mem_req, 1'b0);

        // Normal fetch after a timeout clears the error.
        step(1, 0, 32'h0, "recover.req");
        step(0, 1, 32'h1000_FFFF, "recover.done");
        chk("recover.err",    fetch_err, 1'b0);
        chk("recover.opcode", opcode,    6'h04);

        // mem_ready on the final wait cycle wins over the timeout.
        step(1, 0, 32'h0, "late.req");
        for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 32'h0, "late.wait");
        step(0, 1, 32'h2222_3333, "late.done");
        chk("late.err",   fetch_err, 1'b0);
        chk("late.instr", instr,     32'h2222_3333);

        // Reset abandons an outstanding fetch; a stray mem_ready afterwards is ignored.
        step(1, 0, 32'h0, "abort.req");
        step(0, 0, 32'h0, "abort.wait");
        pulse_reset(1'b0, "abort");
        step(0, 1, 32'h7777_8888, "abort.stray");
        chk("abort.instr", instr,       32'h0);
        chk("abort.valid", instr_valid, 1'b0);
        chk("abort.idle",  mem_req,     1'b0);

        // Random traffic with varying memory responsiveness.
        for (int i = 0; i < 600; i++) begin
            int thr;
            case ((i / 50) % 3)
                0:       thr = 50;
                1:       thr = 8;
                default: thr = 0;
            endcase
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset(1'($urandom_range(0, 1)), "rand.reset");
            end else begin
                step(1'($urandom_range(0, 99) < 40), 1'($urandom_range(0, 99) < thr),
                     $urandom, "rand");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ir_fetch.md
IR_FETCH -- requirements
Module: ir_fetch

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16: the maximum number of WAIT cycles before a fetch is abandoned (legal range 2..255).
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h0000_0000: the word loaded into the instruction register (IR) on timeout.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-005 The block SHALL have port irwrite, input, 1 bit: the controller's request to load a new instruction.
REQ-006 The block SHALL have port mem_rdata, input, 32 bits: the memory read data.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: memory asserts this for one cycle when mem_rdata is valid.
REQ-008 The block SHALL have port mem_req, output, 1 bit: the outstanding fetch request to memory.
REQ-009 The block SHALL have port stall, output, 1 bit: the controller holds its current state while this is high.
REQ-010 The block SHALL have port instr, output, 32 bits: the IR contents.
REQ-011 The block SHALL have port opcode, output, type mips_decls_p::opcode_t: instr[31:26].
REQ-012 The block SHALL have port funct, output, type mips_decls_p::funct_t: instr[5:0].
REQ-013 The block SHALL have ports rs, rt and rd, output, 5 bits each: instr[25:21], instr[20:16] and instr[15:11].
REQ-014 The block SHALL have port imm, output, 16 bits: instr[15:0].
REQ-015 The block SHALL have port instr_valid, output, 1 bit: IR holds a fetched word.
REQ-016 The block SHALL have port fetch_err, output, 1 bit: sticky flag meaning the last fetch timed out.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and WAIT, encoded in a registered state variable.
REQ-018 IDLE, irwrite=1, mem_ready=0: the FSM SHALL go to WAIT, clear the wait counter to 0, and keep IR unchanged.
REQ-019 IDLE, irwrite=1, mem_ready=1 (zero-latency memory): IR SHALL capture mem_rdata at the same edge, the FSM SHALL stay in IDLE, and stall SHALL never assert.
REQ-020 IDLE, irwrite=0: the FSM SHALL hold state, and mem_ready SHALL be ignored.
REQ-021 WAIT, mem_ready=1: IR SHALL capture mem_rdata, the FSM SHALL go to IDLE, instr_valid SHALL be set to 1, and fetch_err SHALL be cleared to 0.
REQ-022 WAIT, mem_ready=0: the wait counter SHALL increment by 1, with an 8-bit counter that never wraps.
REQ-023 WAIT, mem_ready=0 and counter = TIMEOUT-1: IR SHALL load NOP_WORD, fetch_err SHALL be set to 1, instr_valid SHALL be set to 1, and the FSM SHALL go to IDLE.
REQ-024 In WAIT, a mem_ready arriving on the timeout cycle SHALL win: data is captured and fetch_err is not set.
REQ-025 irwrite asserted while in WAIT SHALL be ignored, with no second request and no counter restart.
REQ-026 mem_req SHALL be combinational: 1 when (state=IDLE and irwrite=1) or state=WAIT; otherwise 0.
REQ-027 stall SHALL be combinational: 1 when mem_req=1 and mem_ready=0; otherwise 0.
REQ-028 Field outputs (opcode, funct, rs, rt, rd, imm) SHALL be pure slices of IR, with no extra latency.
REQ-029 instr_valid SHALL remain 1 once set, until reset.
REQ-030 fetch_err SHALL change only on fetch completion (REQ-021 or REQ-023) or on reset.

Reset
REQ-031 When reset=0, regardless of clk, the block SHALL set state=IDLE, IR=32'h0, counter=0, instr_valid=0 and fetch_err=0.
REQ-032 When reset=0, mem_req and stall SHALL be 0 while reset is asserted.
REQ-033 Reset asserted in WAIT SHALL abandon the fetch; a mem_ready arriving after reset release while the FSM is in IDLE with irwrite=0 SHALL be ignored.
REQ-034 Reset release SHALL be synchronised externally; the first edge after release SHALL be able to accept irwrite.

Verification
REQ-035 The bench SHALL cover reset with mem_rdata=32'hDEAD_BEEF toggling -> instr=0, instr_valid=0, mem_req=0, stall=0.
REQ-036 The bench SHALL cover irwrite=1 and mem_ready=1 in the same cycle with mem_rdata=32'h0123_4820 -> after 1 edge opcode=6'h00, funct=6'h20, rd=5'd9, and stall never high.
REQ-037 The bench SHALL cover irwrite pulse then mem_ready after 3 cycles with mem_rdata=32'h8C49_0004 -> stall high for 3 cycles, then opcode=6'h23, imm=16'h0004, fetch_err=0.
REQ-038 The bench SHALL cover irwrite with mem_ready never asserted, TIMEOUT=16 -> stall high for 16 cycles, then instr=32'h0, fetch_err=1, mem_req=0.
REQ-039 The bench SHALL cover the timeout scenario followed by a normal fetch of 32'h1000_FFFF -> fetch_err returns to 0 and opcode=6'h04.
REQ-040 The bench SHALL cover reset=0 asserted during WAIT, then mem_ready pulsed after release with irwrite=0 -> IR remains 0, instr_valid=0, and the FSM stays in IDLE.
